// File: rtl/inst_rom_arbiter.sv
//------------------------------------------------------------------------------
// inst_rom_arbiter: round-robin share of the instruction ROM port between IF and DBG.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module inst_rom_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 64,
   parameter int ALIGN_BITS = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_err,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_err,
   output logic              rom_ce,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_inst
);

   logic              w_if_elig;
   logic              w_dbg_elig;
   logic              w_if_gnt;
   logic              w_dbg_gnt;
   logic              w_any_gnt;
   logic [ADDR_W-1:0] w_sel_addr;
   logic              w_misaligned;
   logic              w_rom_ce;
   logic [DATA_W-1:0] w_rsp_data;

   logic              r_last_dbg;
   logic              r_if_rvalid;
   logic              r_if_err;
   logic [DATA_W-1:0] r_if_rdata;
   logic              r_dbg_rvalid;
   logic              r_dbg_err;
   logic [DATA_W-1:0] r_dbg_rdata;

   assign w_if_elig  = if_req & ~if_flush;
   assign w_dbg_elig = dbg_req;

   // Under contention the requester that did not win last time is granted.
   assign w_if_gnt  = w_if_elig  & (~w_dbg_elig | r_last_dbg);
   assign w_dbg_gnt = w_dbg_elig & (~w_if_elig  | ~r_last_dbg);
   assign w_any_gnt = w_if_gnt | w_dbg_gnt;

   assign w_sel_addr = w_if_gnt ? if_addr : dbg_addr;

   generate
      if (ALIGN_BITS > 0) begin : g_align_chk
         assign w_misaligned = |w_sel_addr[ALIGN_BITS-1:0];
      end else begin : g_no_align_chk
         assign w_misaligned = 1'b0;
      end
   endgenerate

   assign w_rom_ce   = rst & w_any_gnt & ~w_misaligned;
   assign w_rsp_data = w_misaligned ? '0 : rom_inst;

   assign if_gnt   = w_if_gnt;
   assign dbg_gnt  = w_dbg_gnt;
   assign rom_ce   = w_rom_ce;
   assign rom_addr = w_rom_ce ? w_sel_addr : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last_dbg   <= 1'b1;
         r_if_rvalid  <= 1'b0;
         r_if_err     <= 1'b0;
         r_if_rdata   <= '0;
         r_dbg_rvalid <= 1'b0;
         r_dbg_err    <= 1'b0;
         r_dbg_rdata  <= '0;
      end else begin
         if (w_any_gnt) begin
            r_last_dbg <= w_dbg_gnt;
         end
         r_if_rvalid  <= w_if_gnt;
         r_if_err     <= w_if_gnt & w_misaligned;
         r_dbg_rvalid <= w_dbg_gnt;
         r_dbg_err    <= w_dbg_gnt & w_misaligned;
         if (w_if_gnt) begin
            r_if_rdata <= w_rsp_data;
         end
         if (w_dbg_gnt) begin
            r_dbg_rdata <= w_rsp_data;
         end
      end
   end

   // A flush in the response cycle discards the pending fetch response.
   assign if_rvalid  = r_if_rvalid & ~if_flush;
   assign if_err     = r_if_err & ~if_flush;
   assign if_rdata   = r_if_rdata;
   assign dbg_rvalid = r_dbg_rvalid;
   assign dbg_err    = r_dbg_err;
   assign dbg_rdata  = r_dbg_rdata;

endmodule

`default_nettype wire

// File: doc/inst_rom_arbiter.md
Name: inst_rom_arbiter

Overview:
- Shares the single combinational instruction ROM read port between two requesters:
  - the fetch stage (IF);
  - the debug/loader read port (DBG).
- Round-robin arbitration with a req/gnt handshake.
- Drives the ROM chip-enable and address, and returns the selected 64-bit word to the granted requester with one registered cycle of latency.
- Sits between pc_reg/if_id and inst_rom. Also handles fetch flush and misaligned-address errors.

Parameters:
- ADDR_W, 32, byte-address width of both request ports and the ROM address.
- DATA_W, 64, instruction word width.
- ALIGN_BITS, 3, low address bits that must be zero for a legal request (8-byte words).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch read request.
- if_addr  in  ADDR_W  fetch byte address.
- if_flush  in  1  branch/exception flush from ctrl.
- if_gnt  out  1  fetch request accepted this cycle (combinational).
- if_rvalid  out  1  fetch response valid.
- if_rdata  out  DATA_W  fetch response word.
- if_err  out  1  fetch response is a misaligned-address error.
- dbg_req  in  1  debug read request.
- dbg_addr  in  ADDR_W  debug byte address.
- dbg_gnt  out  1  debug request accepted (combinational).
- dbg_rvalid  out  1  debug response valid.
- dbg_rdata  out  DATA_W  debug response word.
- dbg_err  out  1  debug misaligned error.
- rom_ce  out  1  ROM chip enable (combinational, 1 = enabled).
- rom_addr  out  ADDR_W  ROM byte address (combinational).
- rom_inst  in  DATA_W  ROM read data, combinational from rom_ce/rom_addr.

Behaviour:
- Reset (rst=0, async):
  - if_rvalid, dbg_rvalid, if_err, dbg_err = 0;
  - if_rdata, dbg_rdata = 0;
  - last-grant pointer = DBG, so IF wins the first contention.
  - Combinational outputs follow the inputs; rom_ce=0 while in reset.
- Eligibility:
  - IF eligible = if_req & ~if_flush.
  - DBG eligible = dbg_req.
- Arbitration (combinational, cycle N):
  - Only one eligible requester: it is granted.
  - Both eligible: the one NOT in the last-grant pointer is granted.
  - At most one gnt is high per cycle.
  - Pointer updates at the edge only when a grant occurs; no grant leaves the pointer unchanged.
- ROM drive:
  - On a grant with an aligned address: rom_ce=1 and rom_addr = granted address.
  - Otherwise: rom_ce=0 and rom_addr = 0.
- Alignment:
  - Address with addr[ALIGN_BITS-1:0] != 0 is still granted, but rom_ce stays 0.
  - Response at N+1: rvalid=1, err=1, rdata=0.
- Response (cycle N+1, registered):
  - Granted port gets rvalid=1, rdata = rom_inst sampled at the end of N, err as above.
  - Non-granted port: rvalid=0, rdata holds its last value.
  - Latency is exactly 1 cycle; back-to-back grants to the same port give one response per cycle.
- No backpressure on responses: requesters must accept the rvalid cycle.
- Request and address are sampled only in the gnt cycle; a requester may drop req without a grant.
- Flush:
  - if_flush=1 in cycle N: IF is not granted in N.
  - if_flush=1 in cycle N+1 while an IF response is pending: if_rvalid is forced to 0 combinationally for that cycle and the response is discarded (if_err also masked).
  - DBG is unaffected by flush.
- Simultaneous events:
  - A flush in the same cycle as contention gives DBG the grant; the pointer becomes DBG.
  - Reset asserted mid-response clears rvalid immediately (async).

Test Plan:
- Fetch only, sequential reads:
  - Stimulus: if_req=1 with addr 0x0, 0x8, 0x10; dbg_req=0; ROM words 0x2010800000000400, 0x2011000000003800, 0x1031844000000000.
  - Required: if_gnt=1 in every request cycle; if_rvalid=1 one cycle later with those words in order; rom_ce=1 in each request cycle.
- Contention:
  - Stimulus: if_req=dbg_req=1 held for 4 cycles after reset.
  - Required: grants alternate IF, DBG, IF, DBG; each response arrives on the matching port one cycle after its grant; never two gnts in one cycle.
- Misaligned address:
  - Stimulus: dbg_addr=0x4.
  - Required: dbg_gnt=1 and rom_ce=0 in the request cycle; next cycle dbg_rvalid=1, dbg_err=1, dbg_rdata=0.
- Flush:
  - Stimulus: if_req=1 at addr 0x18, then if_flush=1 in the response cycle.
  - Required: if_rvalid=0 in that cycle.
  - Stimulus: if_flush=1 together with if_req.
  - Required: if_gnt=0 and rom_ce=0 when dbg_req=0.
- Async reset mid-operation:
  - Stimulus: drop rst low between clock edges while dbg_rvalid=1.
  - Required: all rvalid/err/rdata go to 0 immediately.
  - Stimulus: then release rst with both requesters active.
  - Required: IF is granted first.
